servo_sequencer: RTL and testbench
==================================

Name: servo_sequencer

Overview:
Motion sequencer for the three-servo arm. It plays back a table of poses, one pulse-width target per servo, and ramps each channel's commanded pulse width toward its target by a bounded step once per 20 ms PWM frame. It dwells at each pose, then advances to the next. Its outputs drive the b inputs of the three existing PWM comparators and replace the switch-driven angle selectors.

Parameters:
NUM_POSES, 4, number of poses in the table (2..16).
STEP, 500, maximum pulse-width change per channel per frame, in clock counts (10 us at 50 MHz).
DWELL_FRAMES, 25, frames held at a reached pose (>=1; 25 = 0.5 s).
MIN_PW, 50000, lower clamp in counts (1.0 ms).
MAX_PW, 100000, upper clamp in counts (2.0 ms).

Ports:
CLK  in  1  system clock, 50 MHz.
RST  in  1  synchronous, active-high reset.
FRAME_TICK  in  1  one-cycle pulse when the 20-bit frame counter equals 0.
START  in  1  level/pulse; begins playback from pose 0 when idle.
STOP  in  1  aborts playback; positions hold.
LOOP  in  1  sampled at end of last pose: 1 = restart at pose 0.
PW1, PW2, PW3  out  17  commanded pulse width per servo, in counts.
BUSY  out  1  high in MOVE or DWELL.
POSE_IDX  out  4  index of current target pose.
AT_TARGET  out  1  all three PWn equal current pose targets.
DONE  out  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- Reset: PW1..3 = HOME_PW (75000), state IDLE, POSE_IDX=0, dwell count 0, BUSY=0, DONE=0; AT_TARGET reflects the comparison against pose 0.
- States: IDLE, MOVE, DWELL.
- IDLE: START=1 -> MOVE, POSE_IDX=0. PWn hold.
- MOVE: on FRAME_TICK, each channel does: d = tgt - PWn; if |d| <= STEP then PWn = tgt, else PWn = PWn +/- STEP. If all three post-update values equal targets -> DWELL, count cleared. Outputs change only in the cycle after FRAME_TICK, so a frame's pulse never changes mid-frame.
- Arithmetic: 18-bit signed difference; no wrap. Targets are clamped to [MIN_PW, MAX_PW] before use. PWn never leaves that range, except HOME_PW at reset.
- DWELL: increment count on each FRAME_TICK. On the DWELL_FRAMES-th tick after entry:
  - if POSE_IDX < NUM_POSES-1: POSE_IDX+1, go to MOVE;
  - else if LOOP: POSE_IDX=0, go to MOVE;
  - else: pulse DONE, go to IDLE. POSE_IDX stays at the last pose.
- STOP=1 in any state: next state IDLE, dwell count cleared, PWn frozen at current values.
- STOP and START in the same cycle: STOP wins.
- START while BUSY: ignored.
- START coincident with FRAME_TICK: enter MOVE; first ramp step occurs on the next FRAME_TICK.
- A pose equal to the current position: reached on the first tick in MOVE, then normal dwell.
- RST mid-motion: all outputs return to reset values in the next cycle.
- Latency: FRAME_TICK -> updated PWn is 1 cycle. DONE is asserted in the cycle after the final dwell tick.

Optional Feature:
Macro SERVO_SEQ_TEACH_EN.
- Defined: adds ports POSE_WE (in, 1), POSE_ADDR (in, 4), POSE_CH (in, 2, values 0..2; 3 is ignored) and POSE_DATA (in, 17). The pose table is a register array, initialised from the package default on RST. A write takes effect the next cycle. Writing the active pose during MOVE retargets immediately. Writes with POSE_ADDR >= NUM_POSES are ignored.
- Undefined: the table is the constant package default and those ports are absent.

Decomposition:
- Package servo_seq_pkg holds:
  - PW_W=17 and HOME_PW=75000;
  - state enum {IDLE, MOVE, DWELL};
  - pose struct {pw[3]};
  - default pose table DEFAULT_POSES: (100000,50000,75000), (50000,100000,90000), (75000,75000,60000), (75000,75000,75000);
  - the clamp function.
- Sub-module servo_ramp, instantiated three times: holds one PWn register and performs the step/clamp/arrive logic on an enable equal to FRAME_TICK and state MOVE. It outputs its arrived flag.

Test Plan:
1. Reset with STEP=5000, DWELL_FRAMES=2: PW1..3=75000, BUSY=0 -> START, then 5 FRAME_TICKs -> PW1=100000, PW2=50000, PW3=75000, enter DWELL, AT_TARGET=1.
2. Ramp granularity, STEP=5000: one tick from 75000 toward 100000 -> PW1=80000 exactly. Non-multiple case, target 98000 from 95000 -> lands on 98000 and does not overshoot.
3. Dwell/advance: 2 ticks in DWELL -> POSE_IDX=1. With LOOP=0, after pose 3 dwell -> exactly one DONE pulse, BUSY=0, PWn=75000.
4. LOOP=1 at the end of pose 3 -> POSE_IDX=0 and MOVE, with no DONE pulse.
5. STOP mid-ramp at PW1=85000 -> IDLE. Further ticks leave PW1=85000. START and STOP in the same cycle -> remains IDLE.
6. SERVO_SEQ_TEACH_EN: write pose0 ch0 = 120000 -> clamped target 100000. Write during MOVE to pose0 ch1 = 60000 -> PW2 settles at 60000.

Source files
------------

// File: rtl/servo_seq_pkg.sv
// Shared types, constants and helpers for the three-servo pose sequencer.
package servo_seq_pkg;

  localparam int unsigned PW_W = 17;
  localparam logic [PW_W-1:0] HOME_PW = 17'd75000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2
  } state_e;

  // pw[0] drives servo 1, pw[1] servo 2, pw[2] servo 3
  typedef struct packed {
    logic [2:0][PW_W-1:0] pw;
  } pose_t;

  // Concatenation order is {servo3, servo2, servo1}
  localparam pose_t DEFAULT_POSES [4] = '{
    pose_t'({17'd75000, 17'd50000,  17'd100000}),
    pose_t'({17'd90000, 17'd100000, 17'd50000}),
    pose_t'({17'd60000, 17'd75000,  17'd75000}),
    pose_t'({17'd75000, 17'd75000,  17'd75000})
  };

  // Tables longer than four poses repeat the default pattern
  function automatic pose_t default_pose(input logic [3:0] idx);
    return DEFAULT_POSES[idx[1:0]];
  endfunction

  function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] v,
                                               input logic [PW_W-1:0] lo,
                                               input logic [PW_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_ramp.sv
// One servo channel: holds the commanded pulse width and ramps it toward a
// clamped target by at most STEP counts each time en is pulsed.
module servo_ramp
  import servo_seq_pkg::*;
#(
  parameter int unsigned STEP   = 500,
  parameter int unsigned MIN_PW = 50000,
  parameter int unsigned MAX_PW = 100000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            en,
  input  logic [PW_W-1:0] tgt,
  output logic [PW_W-1:0] pw,
  output logic            at_tgt,
  output logic            arrive
);

  localparam logic [PW_W-1:0] MIN_C  = PW_W'(MIN_PW);
  localparam logic [PW_W-1:0] MAX_C  = PW_W'(MAX_PW);
  localparam logic [PW_W:0]   STEP_C = (PW_W + 1)'(STEP);

  logic [PW_W-1:0]        tgt_c;
  logic [PW_W-1:0]        pw_step;
  logic signed [PW_W:0]   diff;
  logic [PW_W:0]          mag;

  // Next ramp value; arrive means this step lands exactly on the target
  always_comb begin
    tgt_c   = clamp_pw(tgt, MIN_C, MAX_C);
    diff    = $signed({1'b0, tgt_c}) - $signed({1'b0, pw});
    mag     = diff[PW_W] ? (~diff + 1'b1) : diff;
    arrive  = 1'b0;
    pw_step = tgt_c;
    if (mag <= STEP_C) begin
      arrive = 1'b1;
    end else if (diff[PW_W]) begin
      pw_step = pw - STEP_C[PW_W-1:0];
    end else begin
      pw_step = pw + STEP_C[PW_W-1:0];
    end
    at_tgt = (pw == tgt_c);
  end

  // Pulse-width register, updated only on enabled frame ticks
  always_ff @(posedge CLK) begin
    if (RST) begin
      pw <= HOME_PW;
    end else if (en) begin
      pw <= pw_step;
    end
  end

endmodule

// File: rtl/servo_sequencer.sv
// Pose-table playback sequencer for the three-servo arm. Ramps all channels
// toward the active pose once per PWM frame, dwells, then advances.
// Optional feature macro SERVO_SEQ_TEACH_EN adds a writable pose table.
module servo_sequencer
  import servo_seq_pkg::*;
#(
  parameter int unsigned NUM_POSES    = 4,
  parameter int unsigned STEP         = 500,
  parameter int unsigned DWELL_FRAMES = 25,
  parameter int unsigned MIN_PW       = 50000,
  parameter int unsigned MAX_PW       = 100000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FRAME_TICK,
  input  logic            START,
  input  logic            STOP,
  input  logic            LOOP,
`ifdef SERVO_SEQ_TEACH_EN
  input  logic            POSE_WE,
  input  logic [3:0]      POSE_ADDR,
  input  logic [1:0]      POSE_CH,
  input  logic [PW_W-1:0] POSE_DATA,
`endif
  output logic [PW_W-1:0] PW1,
  output logic [PW_W-1:0] PW2,
  output logic [PW_W-1:0] PW3,
  output logic            BUSY,
  output logic [3:0]      POSE_IDX,
  output logic            AT_TARGET,
  output logic            DONE
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_MOVE  = MOVE;
  localparam logic [1:0] ST_DWELL = DWELL;

  localparam int unsigned CNT_W = $clog2(DWELL_FRAMES + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
  localparam logic [3:0]       LAST_POSE  = 4'(NUM_POSES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [2:0]       arrive;
  logic [2:0]       at_tgt;
  logic             ramp_en;
  pose_t            cur_pose;

`ifdef SERVO_SEQ_TEACH_EN
  // Sized to the full address space so the 4-bit index never exceeds it
  pose_t pose_tbl [16];

  // Teachable pose table; out-of-range addresses and channel 3 are dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        pose_tbl[i] <= default_pose(4'(i));
      end
    end else if (POSE_WE && ({1'b0, POSE_ADDR} < 5'(NUM_POSES))) begin
      case (POSE_CH)
        2'd0:    pose_tbl[POSE_ADDR].pw[0] <= POSE_DATA;
        2'd1:    pose_tbl[POSE_ADDR].pw[1] <= POSE_DATA;
        2'd2:    pose_tbl[POSE_ADDR].pw[2] <= POSE_DATA;
        default: ;
      endcase
    end
  end

  assign cur_pose = pose_tbl[idx_q];
`else
  assign cur_pose = default_pose(idx_q);
`endif

  // STOP freezes positions even when it lands on a frame tick
  assign ramp_en = FRAME_TICK && (state_q == ST_MOVE) && !STOP;

  servo_ramp #(.STEP(STEP), .MIN_PW(MIN_PW), .MAX_PW(MAX_PW)) u_ramp1 (
    .CLK    (CLK),
    .RST    (RST),
    .en     (ramp_en),
    .tgt    (cur_pose.pw[0]),
    .pw     (PW1),
    .at_tgt (at_tgt[0]),
    .arrive (arrive[0])
  );

  servo_ramp #(.STEP(STEP), .MIN_PW(MIN_PW), .MAX_PW(MAX_PW)) u_ramp2 (
    .CLK    (CLK),
    .RST    (RST),
    .en     (ramp_en),
    .tgt    (cur_pose.pw[1]),
    .pw     (PW2),
    .at_tgt (at_tgt[1]),
    .arrive (arrive[1])
  );

  servo_ramp #(.STEP(STEP), .MIN_PW(MIN_PW), .MAX_PW(MAX_PW)) u_ramp3 (
    .CLK    (CLK),
    .RST    (RST),
    .en     (ramp_en),
    .tgt    (cur_pose.pw[2]),
    .pw     (PW3),
    .at_tgt (at_tgt[2]),
    .arrive (arrive[2])
  );

  // Sequencing FSM: pose index, dwell counter and completion pulse
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (STOP) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_d = ST_MOVE;
            idx_d   = '0;
          end
        end
        ST_MOVE: begin
          if (FRAME_TICK && (&arrive)) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
          end
        end
        ST_DWELL: begin
          if (FRAME_TICK) begin
            if (cnt_q == DWELL_LAST) begin
              cnt_d = '0;
              if (idx_q != LAST_POSE) begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_MOVE;
              end else if (LOOP) begin
                idx_d   = '0;
                state_d = ST_MOVE;
              end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign POSE_IDX  = idx_q;
  assign AT_TARGET = &at_tgt;
  assign DONE      = done_q;

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench: two differently parameterised sequencers driven by the
// same stimulus and compared every cycle against a behavioural model.
module tb_servo_sequencer;

  logic clk = 1'b0;
  logic rst, tick, start, stop, loop;
  logic [16:0] pw_a [3];
  logic [16:0] pw_b [3];
  logic        busy [2];
  logic [3:0]  pidx [2];
  logic        att  [2];
  logic        done [2];
`ifdef SERVO_SEQ_TEACH_EN
  logic        we;
  logic [3:0]  waddr;
  logic [1:0]  wch;
  logic [16:0] wdata;
`endif

  always #5 clk = ~clk;

  servo_sequencer #(
    .NUM_POSES(4), .STEP(5000), .DWELL_FRAMES(2), .MIN_PW(50000), .MAX_PW(100000)
  ) u_dut0 (
    .CLK(clk), .RST(rst), .FRAME_TICK(tick), .START(start), .STOP(stop), .LOOP(loop),
`ifdef SERVO_SEQ_TEACH_EN
    .POSE_WE(we), .POSE_ADDR(waddr), .POSE_CH(wch), .POSE_DATA(wdata),
`endif
    .PW1(pw_a[0]), .PW2(pw_a[1]), .PW3(pw_a[2]), .BUSY(busy[0]), .POSE_IDX(pidx[0]),
    .AT_TARGET(att[0]), .DONE(done[0])
  );

  servo_sequencer #(
    .NUM_POSES(3), .STEP(3000), .DWELL_FRAMES(1), .MIN_PW(52000), .MAX_PW(98000)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .FRAME_TICK(tick), .START(start), .STOP(stop), .LOOP(loop),
`ifdef SERVO_SEQ_TEACH_EN
    .POSE_WE(we), .POSE_ADDR(waddr), .POSE_CH(wch), .POSE_DATA(wdata),
`endif
    .PW1(pw_b[0]), .PW2(pw_b[1]), .PW3(pw_b[2]), .BUSY(busy[1]), .POSE_IDX(pidx[1]),
    .AT_TARGET(att[1]), .DONE(done[1])
  );

  // Per-instance configuration
  function automatic int p_num(int k);   return (k == 0) ? 4 : 3;          endfunction
  function automatic int p_step(int k);  return (k == 0) ? 5000 : 3000;    endfunction
  function automatic int p_dwell(int k); return (k == 0) ? 2 : 1;          endfunction
  function automatic int p_lo(int k);    return (k == 0) ? 50000 : 52000;  endfunction
  function automatic int p_hi(int k);    return (k == 0) ? 100000 : 98000; endfunction

  function automatic int dflt(int p, int ch);
    int row [3];
    case (p % 4)
      0:       row = '{100000, 50000, 75000};
      1:       row = '{50000, 100000, 90000};
      2:       row = '{75000, 75000, 60000};
      default: row = '{75000, 75000, 75000};
    endcase
    return row[ch];
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Model: mode 0 = idle, 1 = moving, 2 = dwelling
  int m_mode [2];
  int m_pw   [2][3];
  int m_idx  [2];
  int m_cnt  [2];
  int m_done [2];
  int tbl    [2][16][3];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt0;
  int saw_wrap;
  int prev_idx0;

  function automatic int tgt(int k, int ch);
    return clampi(tbl[k][m_idx[k]][ch], p_lo(k), p_hi(k));
  endfunction

  task automatic model_reset(int k);
    m_mode[k] = 0;
    m_idx[k]  = 0;
    m_cnt[k]  = 0;
    m_done[k] = 0;
    for (int ch = 0; ch < 3; ch++) m_pw[k][ch] = 75000;
    for (int p = 0; p < 16; p++)
      for (int ch = 0; ch < 3; ch++) tbl[k][p][ch] = dflt(p, ch);
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (rst) begin
        model_reset(k);
      end else begin
        if (stop) begin
          m_mode[k] = 0;
          m_cnt[k]  = 0;
        end else if (m_mode[k] == 0) begin
          if (start) begin
            m_mode[k] = 1;
            m_idx[k]  = 0;
          end
        end else if (m_mode[k] == 1) begin
          if (tick) begin
            int all_at;
            all_at = 1;
            for (int ch = 0; ch < 3; ch++) begin
              int t, d;
              t = tgt(k, ch);
              d = t - m_pw[k][ch];
              if (d >= -p_step(k) && d <= p_step(k)) m_pw[k][ch] = t;
              else if (d > 0) m_pw[k][ch] += p_step(k);
              else m_pw[k][ch] -= p_step(k);
              if (m_pw[k][ch] != t) all_at = 0;
            end
            if (all_at != 0) begin
              m_mode[k] = 2;
              m_cnt[k]  = 0;
            end
          end
        end else if (tick) begin
          m_cnt[k]++;
          if (m_cnt[k] == p_dwell(k)) begin
            if (m_idx[k] < p_num(k) - 1) begin
              m_idx[k]++;
              m_mode[k] = 1;
            end else if (loop) begin
              m_idx[k]  = 0;
              m_mode[k] = 1;
            end else begin
              m_done[k] = 1;
              m_mode[k] = 0;
            end
          end
        end
`ifdef SERVO_SEQ_TEACH_EN
        if (we && int'(waddr) < p_num(k) && wch != 2'd3) tbl[k][waddr][wch] = int'(wdata);
`endif
      end
    end
  endtask

  task automatic check_eq(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int at_all;
      at_all = 1;
      for (int ch = 0; ch < 3; ch++) begin
        int got;
        got = (k == 0) ? int'(pw_a[ch]) : int'(pw_b[ch]);
        check_eq($sformatf("u%0d.pw%0d", k, ch + 1), got, m_pw[k][ch]);
        if (m_pw[k][ch] != tgt(k, ch)) at_all = 0;
      end
      check_eq($sformatf("u%0d.busy", k), int'(busy[k]), (m_mode[k] != 0) ? 1 : 0);
      check_eq($sformatf("u%0d.pose_idx", k), int'(pidx[k]), m_idx[k]);
      check_eq($sformatf("u%0d.at_target", k), int'(att[k]), at_all);
      check_eq($sformatf("u%0d.done", k), int'(done[k]), m_done[k]);
    end
    if (done[0]) done_cnt0++;
    if (prev_idx0 == 3 && pidx[0] == 4'd0 && busy[0]) saw_wrap = 1;
    prev_idx0 = int'(pidx[0]);
  endtask

  // Inputs change just after a rising edge and are sampled by the next one
  task automatic cycle(bit s, bit p, bit t);
    start = s;
    stop  = p;
    tick  = t;
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  // Each frame: one tick then two quiet cycles
  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
`ifdef SERVO_SEQ_TEACH_EN
    we = 1'b0; waddr = '0; wch = '0; wdata = '0;
`endif
    done_cnt0 = 0;
    saw_wrap  = 0;
    prev_idx0 = 0;
    for (int k = 0; k < 2; k++) model_reset(k);
    @(negedge clk);

    // Reset state and first pose
    do_reset();
    check_eq("rst_pw1", int'(pw_a[0]), 75000);
    check_eq("rst_busy", int'(busy[0]), 0);
    cycle(1, 0, 0);
    tick_n(5);
    check_eq("pose0_pw1", int'(pw_a[0]), 100000);
    check_eq("pose0_pw2", int'(pw_a[1]), 50000);
    check_eq("pose0_pw3", int'(pw_a[2]), 75000);
    check_eq("pose0_at", int'(att[0]), 1);
    check_eq("u1_partial", int'(pw_b[0]), 90000);
    tick_n(2);
    check_eq("advance_idx", int'(pidx[0]), 1);
    tick_n(1);
    check_eq("u1_no_overshoot", int'(pw_b[0]), 98000);

    // Non-looping completion
    done_cnt0 = 0;
    tick_n(40);
    check_eq("done_pulses", done_cnt0, 1);
    check_eq("end_busy", int'(busy[0]), 0);
    check_eq("end_idx", int'(pidx[0]), 3);
    check_eq("end_pw1", int'(pw_a[0]), 75000);

    // Looping playback, start coincident with a tick
    done_cnt0 = 0;
    saw_wrap  = 0;
    loop = 1'b1;
    cycle(1, 0, 1);
    tick_n(40);
    check_eq("loop_no_done", done_cnt0, 0);
    check_eq("loop_wrap", saw_wrap, 1);
    loop = 1'b0;

    // STOP mid-ramp
    do_reset();
    cycle(1, 0, 0);
    tick_n(2);
    check_eq("stop_pre", int'(pw_a[0]), 85000);
    cycle(0, 1, 0);
    tick_n(3);
    check_eq("stop_hold", int'(pw_a[0]), 85000);
    check_eq("stop_idle", int'(busy[0]), 0);
    cycle(1, 1, 1);
    check_eq("start_stop_idle", int'(busy[0]), 0);

`ifdef SERVO_SEQ_TEACH_EN
    do_reset();
    we = 1'b1; waddr = 4'd0; wch = 2'd0; wdata = 17'd120000;
    cycle(0, 0, 0);
    we = 1'b0;
    cycle(1, 0, 0);
    tick_n(5);
    check_eq("teach_clamp", int'(pw_a[0]), 100000);
    do_reset();
    cycle(1, 0, 0);
    tick_n(1);
    we = 1'b1; waddr = 4'd0; wch = 2'd1; wdata = 17'd60000;
    cycle(0, 0, 0);
    we = 1'b0;
    tick_n(6);
    check_eq("teach_retarget", int'(pw_a[1]), 60000);
`endif

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      loop = $urandom_range(0, 1) != 0;
`ifdef SERVO_SEQ_TEACH_EN
      we    = ($urandom_range(0, 19) == 0);
      waddr = 4'($urandom_range(0, 15));
      wch   = 2'($urandom_range(0, 3));
      wdata = 17'($urandom_range(40000, 131071));
`endif
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) == 0);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
